// File: rtl/nor_sweep_pkg.sv
// Shared types and constants for the exhaustive gate-sweep checker.
package nor_sweep_pkg;

  // Default geometry: 4-input gate, 20 cycles per vector.
  localparam int DEF_N_IN  = 4;
  localparam int DEF_DWELL = 20;

  localparam int VEC_CNT = 2**DEF_N_IN;
  localparam int DWELL_W = $clog2(DEF_DWELL);

  // Truth table of a 4-input NOR indexed by {a,b,c,d}: only vector 0 gives 1.
  localparam logic [15:0] NOR4_TRUTH = 16'h0001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sweep_state_t;

endpackage

// File: rtl/sweep_dwell_timer.sv
// Per-vector dwell counter: counts 0..DWELL-1 while enabled, wraps to 0,
// and flags the final cycle of the dwell window with `last`.
module sweep_dwell_timer #(
  parameter int DWELL = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic last
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins over enable; wrap after the last dwell cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == CNT_LAST);

endmodule

// File: rtl/nor_sweep_checker.sv
// Exhaustive stimulus/response checker for a small combinational gate.
// Walks every input vector, holds each for DWELL cycles, samples the gate
// output on the last dwell cycle and scores it against a latched truth table.
//
// Build option: define NOR_SWEEP_STOP_ON_ERR_EN to end the sweep at the
// first mismatch (stim then holds the failing index).
//
// state | meaning
// IDLE  | waiting for start; outputs hold last sweep's result
// RUN   | driving vectors, sampling and scoring each one
// DONE  | one cycle to publish done/pass, then back to IDLE
module nor_sweep_checker
  import nor_sweep_pkg::*;
#(
  parameter int N_IN  = DEF_N_IN,
  parameter int DWELL = DEF_DWELL
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   expected,
  input  logic                 dut_out,
  output logic [N_IN-1:0]      stim,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        err_count,
  output logic [N_IN-1:0]      first_err_idx
);

  localparam int VEC_N = 2**N_IN;
  localparam logic [N_IN:0]   ERR_MAX   = (N_IN+1)'(VEC_N);
  localparam logic [N_IN-1:0] STIM_LAST = '1;

  sweep_state_t state_q, state_d;

  logic [VEC_N-1:0] expected_q, expected_d;
  logic [N_IN-1:0]  stim_q, stim_d;
  logic [N_IN:0]    err_q, err_d;
  logic [N_IN-1:0]  first_q, first_d;
  logic             pass_q, pass_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic timer_clear;
  logic timer_en;
  logic dwell_last;
  logic mismatch;

  sweep_dwell_timer #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (timer_clear),
    .en    (timer_en),
    .last  (dwell_last)
  );

  // Next-state and scoreboard update; status outputs lag the state by one
  // edge so every output comes straight from a flop.
  always_comb begin
    state_d     = state_q;
    expected_d  = expected_q;
    stim_d      = stim_q;
    err_d       = err_q;
    first_d     = first_q;
    pass_d      = pass_q;
    done_d      = 1'b0;
    busy_d      = (state_q == RUN);
    timer_clear = 1'b0;
    timer_en    = 1'b0;
    mismatch    = 1'b0;

    case (state_q)
      IDLE: begin
        timer_clear = 1'b1;
        if (start) begin
          state_d    = RUN;
          expected_d = expected;
          stim_d     = '0;
          err_d      = '0;
          first_d    = '0;
          pass_d     = 1'b0;
        end
      end

      RUN: begin
        timer_en = 1'b1;
        if (dwell_last) begin
          mismatch = (dut_out != expected_q[stim_q]);
          if (mismatch) begin
            // Every vector can fail, so the count must stop at VEC_N.
            if (err_q != ERR_MAX) begin
              err_d = err_q + 1'b1;
            end
            if (err_q == '0) begin
              first_d = stim_q;
            end
          end
`ifdef NOR_SWEEP_STOP_ON_ERR_EN
          if (mismatch || (stim_q == STIM_LAST)) begin
            state_d = DONE;
          end else begin
            stim_d = stim_q + 1'b1;
          end
`else
          if (stim_q == STIM_LAST) begin
            state_d = DONE;
          end else begin
            stim_d = stim_q + 1'b1;
          end
`endif
        end
      end

      DONE: begin
        timer_clear = 1'b1;
        done_d      = 1'b1;
        pass_d      = (err_q == '0);
        state_d     = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      expected_q <= '0;
      stim_q     <= '0;
      err_q      <= '0;
      first_q    <= '0;
      pass_q     <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      stim_q     <= stim_d;
      err_q      <= err_d;
      first_q    <= first_d;
      pass_q     <= pass_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign stim          = stim_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign first_err_idx = first_q;

endmodule

// File: tb/tb_nor_sweep_checker.sv
// Self-checking bench for nor_sweep_checker: a behavioural gate model drives
// dut_out, a reference sweep model predicts each sweep's result at start and
// pushes it to a scoreboard queue, popped when done is observed.
module tb_nor_sweep_checker;

  localparam int DW = 20;
  localparam int NV = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] expected = '0;
  logic        dut_out;
  logic [3:0]  stim;
  logic        busy;
  logic        done;
  logic        pass;
  logic [4:0]  err_count;
  logic [3:0]  first_err_idx;

  int dut_mode = 0;   // 0: correct NOR4, 1: stuck-at-0, 2: stuck-at-1
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int err;
    int first;
    bit pass;
    int d_edge;
    int last_idx;
  } exp_t;

  exp_t sb_q[$];

  nor_sweep_checker #(
    .N_IN  (4),
    .DWELL (DW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .expected      (expected),
    .dut_out       (dut_out),
    .stim          (stim),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_count     (err_count),
    .first_err_idx (first_err_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    if (dut_mode == 0) dut_out = ~|stim;
    else               dut_out = (dut_mode == 2);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  function automatic exp_t model_sweep(input logic [15:0] exp, input int mode, input int k);
    exp_t r;
    logic o;
    r.err = 0;
    r.first = 0;
    r.last_idx = NV - 1;
    for (int i = 0; i < NV; i++) begin
      o = (mode == 0) ? (i == 0) : (mode == 2);
      if (o != exp[i]) begin
        if (r.err == 0) r.first = i;
        if (r.err < NV) r.err++;
`ifdef NOR_SWEEP_STOP_ON_ERR_EN
        r.last_idx = i;
        break;
`endif
      end
    end
    r.pass = (r.err == 0);
    r.d_edge = k + DW * (r.last_idx + 1) + 1;
    return r;
  endfunction

  // Raise start before the next edge k and log the predicted result.
  task automatic begin_sweep(input logic [15:0] exp, input int mode, output int k);
    @(negedge clk);
    expected = exp;
    dut_mode = mode;
    start = 1'b1;
    k = cyc + 1;
    sb_q.push_back(model_sweep(exp, mode, k));
  endtask

  // Follow a sweep accepted at edge k, checking stim/busy/done every cycle,
  // and score the result against the queue when done appears.
  task automatic watch_sweep(input string name, input int k, input bit repulse,
                             input bit hold, output int d_edge);
    exp_t r;
    int e;
    int exp_stim;
    bit exp_busy;
    bit exp_done;
    r = sb_q[0];
    d_edge = r.d_edge;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      e = cyc;
      if (e == k) start = 1'b0;
      if (repulse && e == k + 7*DW + 5) start = 1'b1;
      if (repulse && e == k + 7*DW + 6) start = 1'b0;
      if (hold && e == r.d_edge - 3) start = 1'b1;

      exp_stim = (e - k) / DW;
      if (exp_stim > r.last_idx) exp_stim = r.last_idx;
      exp_busy = (e > k) && (e < r.d_edge);
      exp_done = (e == r.d_edge);

      checks++;
      if (stim !== 4'(exp_stim)) begin
        errors++;
        $display("FAIL %s stim at k+%0d: got %0d want %0d", name, e - k, stim, exp_stim);
      end
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL %s busy at k+%0d: got %b want %b", name, e - k, busy, exp_busy);
      end
      checks++;
      if (done !== exp_done) begin
        errors++;
        $display("FAIL %s done at k+%0d: got %b want %b", name, e - k, done, exp_done);
      end

      if (done === 1'b1 || e >= r.d_edge) begin
        r = sb_q.pop_front();
        checks++;
        if (err_count !== 5'(r.err)) begin
          errors++;
          $display("FAIL %s err_count: got %0d want %0d", name, err_count, r.err);
        end
        checks++;
        if (pass !== r.pass) begin
          errors++;
          $display("FAIL %s pass: got %b want %b", name, pass, r.pass);
        end
        if (r.err != 0) begin
          checks++;
          if (first_err_idx !== 4'(r.first)) begin
            errors++;
            $display("FAIL %s first_err_idx: got %0d want %0d", name, first_err_idx, r.first);
          end
        end
        return;
      end
    end
    errors++;
    $display("FAIL %s timeout: no done within 400 cycles of start", name);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({stim, busy, done, pass, err_count, first_err_idx} !== 16'h0) begin
      errors++;
      $display("FAIL reset outputs: got stim=%0d busy=%b done=%b pass=%b err=%0d first=%0d want all 0",
               stim, busy, done, pass, err_count, first_err_idx);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_nor_pass(input string name);
    int k, d;
    begin_sweep(16'h0001, 0, k);
    watch_sweep(name, k, 1'b0, 1'b0, d);
    checks++;
    if (d - k != 321) begin
      errors++;
      $display("FAIL %s done edge offset: got %0d want 321", name, d - k);
    end
  endtask

  task automatic test_stuck0();
    int k, d;
    begin_sweep(16'h0001, 1, k);
    watch_sweep("stuck0", k, 1'b0, 1'b0, d);
  endtask

  task automatic test_saturation();
    int k, d;
    begin_sweep(16'hFFFE, 0, k);
    watch_sweep("saturate", k, 1'b0, 1'b0, d);
  endtask

  task automatic test_stuck1();
    int k, d;
    begin_sweep(16'h0001, 2, k);
    watch_sweep("stuck1", k, 1'b0, 1'b0, d);
  endtask

  task automatic test_back_to_back();
    int k, d, k2, d2;
    begin_sweep(16'h0001, 0, k);
    watch_sweep("repulse", k, 1'b1, 1'b1, d);
    // start is still high here; the FSM accepts it on the next edge.
    k2 = cyc + 1;
    sb_q.push_back(model_sweep(16'h0001, 0, k2));
    checks++;
    if (k2 != d + 1) begin
      errors++;
      $display("FAIL restart edge: got %0d want %0d", k2, d + 1);
    end
    watch_sweep("held_start", k2, 1'b0, 1'b0, d2);
  endtask

  task automatic test_midsweep_reset();
    int k;
    int mode;
    exp_t dropped;
`ifdef NOR_SWEEP_STOP_ON_ERR_EN
    mode = 0;
`else
    mode = 1;
`endif
    begin_sweep(16'h0001, mode, k);
    dropped = sb_q.pop_back();
    for (int n = 0; n <= 5*DW; n++) begin
      @(negedge clk);
      if (cyc == k) start = 1'b0;
    end
    checks++;
    if (stim !== 4'd5 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pre-reset stim/busy: got %0d/%b want 5/1", stim, busy);
    end
    checks++;
    if (err_count !== 5'(dropped.err)) begin
      errors++;
      $display("FAIL pre-reset err_count: got %0d want %0d", err_count, dropped.err);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({stim, busy, done, pass, err_count, first_err_idx} !== 16'h0) begin
      errors++;
      $display("FAIL midsweep reset: got stim=%0d busy=%b done=%b pass=%b err=%0d first=%0d want all 0",
               stim, busy, done, pass, err_count, first_err_idx);
    end
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL after reset idle: got done=%b busy=%b want 0/0", done, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nor_pass("nor_pass");
    test_stuck0();
    test_saturation();
    test_stuck1();
    test_back_to_back();
    test_midsweep_reset();
    test_nor_pass("recover");
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nor_sweep_checker.md
# nor_sweep_checker

Synthesizable self-checking stimulus/response engine for small combinational gate blocks such as the 4-input NOR of the Week04 lab. On `start` it walks every input vector 0…2^N_IN−1 on `stim`, dwells a fixed number of cycles per vector, samples the DUT output, and compares it against a captured expected truth table. It reports mismatch count, first failing vector and pass/fail. It sits between the board's start button/LEDs and the gate under test, and does in hardware what the exhaustive simulation sweep does on the bench.

## Interface
- `N_IN`, 4, DUT input count; vector space 2^N_IN.
- `DWELL`, 20, cycles each vector is held (≥2).
- `clk`  in  1  rising-edge clock, the only clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  level, sampled in IDLE only.
- `expected`  in  2^N_IN  expected DUT output per vector index; captured on accepted start.
- `dut_out`  in  1  DUT response.
- `stim`  out  N_IN  vector driven to DUT, bit N_IN−1 = input `a`.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse at sweep end.
- `pass`  out  1  valid from `done` until next accepted start; 1 = zero mismatches.
- `err_count`  out  N_IN+1  mismatches in current/last sweep.
- `first_err_idx`  out  N_IN  vector index of first mismatch; valid when `err_count`≠0.

## Operation
- States: IDLE → RUN → DONE → IDLE.
- IDLE: `start`=1 at an edge → RUN; `expected` latched; `stim`, dwell counter, `err_count`, `first_err_idx` and `pass` cleared.
- RUN: `stim` = vector index; dwell counter counts 0…DWELL−1. On count DWELL−1, `dut_out` is compared with `expected_q[stim]`. Mismatch: `err_count`++; `first_err_idx`←`stim` if `err_count` was 0. Then the index increments and the counter wraps to 0.
- After the sample of index 2^N_IN−1 → DONE. `stim` holds its last value.
- DONE: `done`=1 and `pass`=(`err_count`==0) for one cycle, then IDLE.
- `start` in RUN/DONE is ignored. `start` held high restarts a sweep the cycle after returning to IDLE.
- `err_count` saturates at 2^N_IN. This saturation is reachable, so it does not wrap.
- `rst_n`=0 at any edge, including mid-sweep, forces IDLE immediately. Reset values: `stim`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_err_idx`=0, `expected_q`=0.

## Timing
- Accepted start at edge k: `busy`=1 and `stim`=0 from k+1.
- Vector i is driven for edges k+1+i·DWELL … k+(i+1)·DWELL. It is sampled at the last of those edges, which gives DWELL−1 cycles of settle.
- `done` is high during the cycle after edge k+1+2^N_IN·DWELL. With defaults that is edge k+321.
- `busy` falls at the same edge at which `done` rises.
- All outputs are registered. No combinational path runs from inputs to outputs.

## Configuration
- `NOR_SWEEP_STOP_ON_ERR_EN` defined: the first mismatch sends the FSM to DONE right after that sample. `err_count` ends at 1, `pass`=0, and `stim` holds the failing index.
- Undefined: every vector is always swept and all mismatches are counted.

## Structure
- Package `nor_sweep_pkg`:
  - state enum `sweep_state_t` (IDLE, RUN, DONE)
  - localparams `VEC_CNT = 2**N_IN`, `DWELL_W = $clog2(DWELL)`
  - constant `NOR4_TRUTH = 16'h0001`
- One sub-module, `sweep_dwell_timer`. It holds the dwell counter with `clear`/`en` inputs and a `last` output, asserted at count DWELL−1.
- FSM and scoreboard stay in the top module.

## Test plan
- Correct NOR4 behavioural DUT, `expected`=16'h0001, start pulse at edge k → `stim` steps 0…15 every 20 cycles, `done` at k+321, `pass`=1, `err_count`=0.
- DUT stuck-at-0, `expected`=16'h0001 → `pass`=0, `err_count`=1, `first_err_idx`=0.
- Correct NOR4 DUT, `expected`=16'hFFFE → `err_count`=16 (saturation limit), `first_err_idx`=0, `pass`=0.
- `start` re-pulsed at vector 7 in RUN → ignored, sweep completes, single `done`. Then `start` held high → new sweep begins the cycle after DONE.
- `rst_n`=0 for one edge while `stim`=5 → next cycle `stim`=0, `busy`=0, `err_count`=0, `pass`=0, no `done`.
- With `NOR_SWEEP_STOP_ON_ERR_EN`, DUT stuck-at-1, `expected`=16'h0001 → mismatch at index 1, `done` at edge k+41, `err_count`=1, `first_err_idx`=1, `stim`=1.
